deframer: RTL and testbench
===========================

DEFRAMER -- requirements
Module: deframer

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 64, beats per frame (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, tdata width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH  framed input data.
REQ-006 SHALL have port s_axis_tvalid  input  1  input beat valid.
REQ-007 SHALL have port s_axis_tready  output  1  input beat accepted when high with tvalid.
REQ-008 SHALL have port s_axis_tlast  input  1  sender's end-of-frame marker.
REQ-009 SHALL have port m_axis_tdata  output  DATA_WIDTH  forwarded data.
REQ-010 SHALL have port m_axis_tvalid  output  1  output beat valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-012 SHALL have port m_axis_tlast  output  1  regenerated end-of-frame, high on beat FRAME_SIZE of each frame.
REQ-013 SHALL have port in_sync  output  1  high in RUN state.
REQ-014 SHALL have port frame_ok  output  1  one-cycle pulse: frame ended with tlast exactly on beat FRAME_SIZE.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse: framing violation detected.
REQ-016 SHALL have port err_count  output  16  saturating count of frame_err pulses.

Function
REQ-017 SHALL implement states HUNT and RUN; reset state HUNT.
REQ-018 In HUNT: s_axis_tready SHALL be 1; accepted beats SHALL be dropped (never forwarded).
REQ-019 In HUNT: an accepted beat with s_axis_tlast=1 SHALL move the FSM to RUN with beat counter = 0; that beat is dropped.
REQ-020 In RUN: s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready); single output register, no bubbles under continuous flow.
REQ-021 In RUN: accepted beat SHALL appear on m_axis_tdata with m_axis_tvalid=1 on the next cycle (latency 1).
REQ-022 m_axis_tdata/tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 Beat counter width SHALL be $clog2(FRAME_SIZE)+1 bits; counts accepted RUN beats 0..FRAME_SIZE-1.
REQ-024 m_axis_tlast SHALL be 1 for a beat accepted at counter==FRAME_SIZE-1 or with s_axis_tlast=1; else 0.
REQ-025 Counter==FRAME_SIZE-1 with s_axis_tlast=1: frame_ok pulse, counter -> 0, stay RUN.
REQ-026 Counter<FRAME_SIZE-1 with s_axis_tlast=1 (short frame): beat forwarded with m_axis_tlast=1, frame_err pulse, counter -> 0, stay RUN.
REQ-027 Counter==FRAME_SIZE-1 with s_axis_tlast=0 (long frame): beat forwarded with m_axis_tlast=1, frame_err pulse, counter -> 0, FSM -> HUNT.
REQ-028 frame_ok/frame_err SHALL assert the cycle after the causing beat's acceptance, coincident with that beat first presented on m_axis; never both in one cycle.
REQ-029 err_count SHALL increment by 1 per frame_err and saturate at 16'hFFFF (no wrap).
REQ-030 In HUNT, a beat still held in the output register SHALL drain normally per REQ-022.
REQ-031 in_sync SHALL be registered: 1 exactly while state is RUN.

Reset
REQ-032 On reset_n=0, asynchronously: state HUNT, counter 0, m_axis_tvalid 0, m_axis_tlast 0, in_sync 0, frame_ok 0, frame_err 0, err_count 0; m_axis_tdata 0.
REQ-033 Reset mid-frame SHALL discard any held output beat; after release, block hunts for next tlast.
REQ-034 Reset release SHALL be synchronized externally; block needs no cycles after release before accepting beats.

Verification (FRAME_SIZE=4, DATA_WIDTH=32)
REQ-035 Sync: after reset send beats 0xA0..0xA2 with tlast on 0xA2, then 0x10..0x13 tlast on 0x13, m_tready=1 -> 0xA* dropped; 0x10..0x13 out, m_tlast only on 0x13, one frame_ok, in_sync=1.
REQ-036 Backpressure: in RUN, m_tready low 3 cycles mid-frame -> s_tready low, m_tdata held stable, no beat lost or duplicated, order preserved.
REQ-037 Short frame: in RUN send 0x20,0x21 with tlast on 0x21, then good frame -> 0x21 out with m_tlast=1, frame_err=1, err_count=1, next frame gives frame_ok.
REQ-038 Long frame: in RUN send 0x30..0x35 no tlast until 0x35 -> 0x30..0x33 out, m_tlast on 0x33, frame_err, in_sync=0; 0x34,0x35 dropped; resync on next frame.
REQ-039 Saturation: force 65537 short frames -> err_count stops at 0xFFFF.
REQ-040 Async reset asserted with m_tvalid=1 and m_tready=0 -> m_tvalid 0 immediately, in_sync 0, err_count 0.

Source files
------------

// File: rtl/deframer_if.sv
// Stream bundle for the deframer: input AXI-Stream side (s_axis_*) and output side (m_axis_*).
// The slave modport is the deframer's view; master is the view of whatever drives and sinks it.
interface deframer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/deframer.sv
// Frame aligner: hunts for a sender tlast, then forwards fixed-length frames with a
// regenerated tlast, flagging short/long frames and counting framing errors.
module deframer #(
    parameter int unsigned FRAME_SIZE = 64,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    deframer_if.slave     bus,
    output logic          in_sync,
    output logic          frame_ok,
    output logic          frame_err,
    output logic [15:0]   err_count
);
    localparam int unsigned CW = $clog2(FRAME_SIZE) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_SIZE - 1);

    typedef enum logic {HUNT, RUN} state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic                  m_tvalid_q;
    logic                  m_tlast_q;
    logic                  in_sync_q;
    logic                  frame_ok_q;
    logic                  frame_err_q;
    logic [15:0]           err_count_q;

    logic s_tready_c;
    logic accept_c;
    logic at_last_c;
    logic ok_d;
    logic err_d;

    // Handshake and frame-boundary decode for the current cycle
    always_comb begin
        s_tready_c = 1'b1;
        if (state_q == RUN) begin
            s_tready_c = !m_tvalid_q || bus.m_axis_tready;
        end
        accept_c  = bus.s_axis_tvalid && s_tready_c;
        at_last_c = (cnt_q == LAST_IDX);
        ok_d      = (state_q == RUN) && accept_c && at_last_c && bus.s_axis_tlast;
        err_d     = (state_q == RUN) && accept_c && (at_last_c ^ bus.s_axis_tlast);
    end

    assign bus.s_axis_tready = s_tready_c;
    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tvalid = m_tvalid_q;
    assign bus.m_axis_tlast  = m_tlast_q;
    assign in_sync           = in_sync_q;
    assign frame_ok          = frame_ok_q;
    assign frame_err         = frame_err_q;
    assign err_count         = err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            in_sync_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            frame_ok_q  <= ok_d;
            frame_err_q <= err_d;
            if (err_d && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end

            // Output register drains in either state; only RUN refills it
            if (m_tvalid_q && bus.m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                HUNT: begin
                    if (accept_c && bus.s_axis_tlast) begin
                        state_q   <= RUN;
                        in_sync_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        m_tdata_q  <= bus.s_axis_tdata;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= at_last_c || bus.s_axis_tlast;
                        if (at_last_c) begin
                            cnt_q <= '0;
                            if (!bus.s_axis_tlast) begin
                                state_q   <= HUNT;
                                in_sync_q <= 1'b0;
                            end
                        end else if (bus.s_axis_tlast) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= HUNT;
                    in_sync_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_deframer.sv
// Directed bench for deframer with FRAME_SIZE=4: sync, backpressure, short/long frames,
// error-count saturation and asynchronous reset with a held output beat.
module tb_deframer;
    localparam int unsigned FS = 4;
    localparam int unsigned DW = 32;

    logic        clk;
    logic        reset_n;
    logic        in_sync;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] err_count;

    deframer_if #(.DATA_WIDTH(DW)) bus ();

    deframer #(.FRAME_SIZE(FS), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .in_sync   (in_sync),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    int total = 0;
    int bad   = 0;
    int ok_seen   = 0;
    int err_seen  = 0;
    int both_seen = 0;
    bit collect   = 1'b1;
    logic [32:0] obs_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output beats and status pulses sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (collect && bus.m_axis_tvalid && bus.m_axis_tready)
                obs_q.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
            if (frame_ok)  ok_seen++;
            if (frame_err) err_seen++;
            if (frame_ok && frame_err) both_seen++;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        int waited = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_axis_tready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.s_axis_tready) begin
            total++; bad++;
            $display("FAIL send_timeout data=%h tready=%b required=1", d, bus.s_axis_tready);
        end
        @(posedge clk); #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #7;
        total++; if (in_sync !== 1'b0) begin bad++; $display("FAIL rst_in_sync got=%b exp=0", in_sync); end
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid got=%b exp=0", bus.m_axis_tvalid); end
        total++; if (bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_m_tlast got=%b exp=0", bus.m_axis_tlast); end
        total++; if (bus.m_axis_tdata !== 32'h0) begin bad++; $display("FAIL rst_m_tdata got=%h exp=0", bus.m_axis_tdata); end
        total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rst_err_count got=%h exp=0", err_count); end
        total++; if ({frame_ok, frame_err} !== 2'b00) begin bad++; $display("FAIL rst_pulses got=%b exp=00", {frame_ok, frame_err}); end
        total++; if (bus.s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_s_tready got=%b exp=1", bus.s_axis_tready); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sync;
        int base = obs_q.size();
        int ok0  = ok_seen;
        int er0  = err_seen;
        logic [32:0] exp_q[$] = '{{1'b0, 32'h10}, {1'b0, 32'h11}, {1'b0, 32'h12}, {1'b1, 32'h13}};
        bus.m_axis_tready = 1'b1;
        send_beat(32'hA0, 1'b0);
        total++; if (in_sync !== 1'b0) begin bad++; $display("FAIL sync_hunt_in_sync got=%b exp=0", in_sync); end
        send_beat(32'hA1, 1'b0);
        send_beat(32'hA2, 1'b1);
        total++; if (in_sync !== 1'b1) begin bad++; $display("FAIL sync_in_sync got=%b exp=1", in_sync); end
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL sync_hunt_dropped got=%b exp=0", bus.m_axis_tvalid); end
        send_beat(32'h10, 1'b0);
        total++; if ({bus.m_axis_tvalid, bus.m_axis_tdata} !== {1'b1, 32'h10}) begin
            bad++; $display("FAIL sync_latency got=%b/%h exp=1/00000010", bus.m_axis_tvalid, bus.m_axis_tdata); end
        send_beat(32'h11, 1'b0);
        send_beat(32'h12, 1'b0);
        send_beat(32'h13, 1'b1);
        total++; if ({frame_ok, frame_err, bus.m_axis_tlast} !== 3'b101) begin
            bad++; $display("FAIL sync_ok_with_last got=%b exp=101", {frame_ok, frame_err, bus.m_axis_tlast}); end
        idle(3);
        total++; if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL sync_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            total++; if (obs_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL sync_beat%0d got=%h exp=%h", i, obs_q[base + i], exp_q[i]); end
        end
        total++; if (ok_seen - ok0 != 1 || err_seen != er0) begin bad++; $display("FAIL sync_pulses ok=%0d err=%0d exp=1/0", ok_seen - ok0, err_seen - er0); end
    endtask

    task automatic test_backpressure;
        int base = obs_q.size();
        int ok0  = ok_seen;
        logic [32:0] exp_q[$] = '{{1'b0, 32'h40}, {1'b0, 32'h41}, {1'b0, 32'h42}, {1'b1, 32'h43}};
        send_beat(32'h40, 1'b0);
        bus.m_axis_tready = 1'b0;
        bus.s_axis_tdata  = 32'h41;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if ({bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tdata} !== {1'b0, 1'b1, 32'h40}) begin
                bad++; $display("FAIL bp_hold%0d got=%b/%b/%h exp=0/1/00000040", c, bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tdata); end
        end
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b1;
        send_beat(32'h41, 1'b0);
        send_beat(32'h42, 1'b0);
        send_beat(32'h43, 1'b1);
        idle(3);
        total++; if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            total++; if (obs_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, obs_q[base + i], exp_q[i]); end
        end
        total++; if (ok_seen - ok0 != 1) begin bad++; $display("FAIL bp_ok got=%0d exp=1", ok_seen - ok0); end
    endtask

    task automatic test_short_frame;
        int base = obs_q.size();
        int ok0  = ok_seen;
        logic [32:0] exp_q[$] = '{{1'b0, 32'h20}, {1'b1, 32'h21}, {1'b0, 32'h50}, {1'b0, 32'h51}, {1'b0, 32'h52}, {1'b1, 32'h53}};
        send_beat(32'h20, 1'b0);
        send_beat(32'h21, 1'b1);
        total++; if ({bus.m_axis_tdata, bus.m_axis_tlast, frame_err, frame_ok} !== {32'h21, 3'b110}) begin
            bad++; $display("FAIL short_err got=%h/%b/%b/%b exp=00000021/1/1/0", bus.m_axis_tdata, bus.m_axis_tlast, frame_err, frame_ok); end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL short_err_count got=%0d exp=1", err_count); end
        total++; if (in_sync !== 1'b1) begin bad++; $display("FAIL short_in_sync got=%b exp=1", in_sync); end
        for (int i = 0; i < 4; i++) send_beat(32'h50 + i, i == 3);
        total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL short_next_ok got=%b exp=1", frame_ok); end
        idle(3);
        total++; if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL short_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            total++; if (obs_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL short_beat%0d got=%h exp=%h", i, obs_q[base + i], exp_q[i]); end
        end
        total++; if (ok_seen - ok0 != 1) begin bad++; $display("FAIL short_ok_total got=%0d exp=1", ok_seen - ok0); end
    endtask

    task automatic test_long_frame;
        int base = obs_q.size();
        logic [32:0] exp_q[$] = '{{1'b0, 32'h30}, {1'b0, 32'h31}, {1'b0, 32'h32}, {1'b1, 32'h33},
                                  {1'b0, 32'h60}, {1'b0, 32'h61}, {1'b0, 32'h62}, {1'b1, 32'h63}};
        for (int i = 0; i < 4; i++) send_beat(32'h30 + i, 1'b0);
        total++; if ({bus.m_axis_tlast, frame_err, frame_ok, in_sync} !== 4'b1100) begin
            bad++; $display("FAIL long_err got=%b exp=1100", {bus.m_axis_tlast, frame_err, frame_ok, in_sync}); end
        total++; if (err_count !== 16'd2) begin bad++; $display("FAIL long_err_count got=%0d exp=2", err_count); end
        send_beat(32'h34, 1'b0);
        send_beat(32'h35, 1'b1);
        total++; if (in_sync !== 1'b1) begin bad++; $display("FAIL long_resync got=%b exp=1", in_sync); end
        for (int i = 0; i < 4; i++) send_beat(32'h60 + i, i == 3);
        total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL long_next_ok got=%b exp=1", frame_ok); end
        idle(3);
        total++; if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL long_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            total++; if (obs_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL long_beat%0d got=%h exp=%h", i, obs_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_saturation;
        collect = 1'b0;
        for (int i = 0; i < 65531; i++) send_beat(32'hEE, 1'b1);
        total++; if (err_count !== 16'hFFFD) begin bad++; $display("FAIL sat_fffd got=%h exp=fffd", err_count); end
        send_beat(32'hEE, 1'b1);
        total++; if (err_count !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h exp=fffe", err_count); end
        send_beat(32'hEE, 1'b1);
        total++; if (err_count !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h exp=ffff", err_count); end
        send_beat(32'hEE, 1'b1);
        send_beat(32'hEE, 1'b1);
        total++; if ({frame_err, err_count} !== {1'b1, 16'hFFFF}) begin bad++; $display("FAIL sat_hold got=%b/%h exp=1/ffff", frame_err, err_count); end
        idle(2);
        collect = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        int base;
        int ok0;
        logic [32:0] exp_q[$] = '{{1'b0, 32'h80}, {1'b0, 32'h81}, {1'b0, 32'h82}, {1'b1, 32'h83}};
        bus.m_axis_tready = 1'b0;
        send_beat(32'h70, 1'b0);
        total++; if ({bus.m_axis_tvalid, bus.m_axis_tdata} !== {1'b1, 32'h70}) begin
            bad++; $display("FAIL rmid_pre got=%b/%h exp=1/00000070", bus.m_axis_tvalid, bus.m_axis_tdata); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({bus.m_axis_tvalid, in_sync} !== 2'b00) begin bad++; $display("FAIL rmid_async got=%b exp=00", {bus.m_axis_tvalid, in_sync}); end
        total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rmid_err_count got=%h exp=0", err_count); end
        @(negedge clk);
        reset_n = 1'b1;
        bus.m_axis_tready = 1'b1;
        base = obs_q.size();
        ok0  = ok_seen;
        @(posedge clk); #1;
        send_beat(32'h71, 1'b0);
        send_beat(32'h72, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(32'h80 + i, i == 3);
        idle(3);
        total++; if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            total++; if (obs_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL rmid_beat%0d got=%h exp=%h", i, obs_q[base + i], exp_q[i]); end
        end
        total++; if (ok_seen - ok0 != 1) begin bad++; $display("FAIL rmid_ok got=%0d exp=1", ok_seen - ok0); end
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b1;
        test_reset();
        test_sync();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_saturation();
        test_reset_mid_frame();
        total++; if (both_seen != 0) begin bad++; $display("FAIL ok_err_overlap got=%0d exp=0", both_seen); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
